// File: rtl/dmem_responder_if.sv
// Request/response bundle between a load/store unit and the data-memory responder.
interface dmem_responder_if;
   logic        enable;
   logic        wr;
   logic [15:0] addr;
   logic [15:0] data_in;
   logic [15:0] data_out;
   logic        data_valid;
   logic        busy;
   logic        misalign;

   modport master (
      output enable, wr, addr, data_in,
      input  data_out, data_valid, busy, misalign
   );

   modport slave (
      input  enable, wr, addr, data_in,
      output data_out, data_valid, busy, misalign
   );
endinterface

// File: rtl/dmem_responder.sv
// Fixed-latency 16-bit data memory: one request in flight, completes LATENCY cycles
// after acceptance with a one-cycle data_valid pulse.
module dmem_responder #(
   parameter int unsigned LATENCY    = 4,
   parameter int unsigned DEPTH_LOG2 = 8
) (
   input logic             clk,
   input logic             rst_n,
   dmem_responder_if.slave mem_io
);

   localparam int unsigned Words   = 2 ** DEPTH_LOG2;
   localparam logic [3:0]  CntLoad = 4'(LATENCY - 1);

   typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

   state_e                state_q, state_d;
   logic [3:0]            cnt_q, cnt_d;
   logic [DEPTH_LOG2-1:0] idx_q, idx_d;
   logic                  wr_q, wr_d;
   logic                  addr0_q, addr0_d;
   logic [15:0]           wdata_q, wdata_d;
   logic [15:0]           dout_q, dout_d;
   logic                  misalign_q, misalign_d;

   logic [15:0]           mem [Words];
   logic                  accept;
   logic                  finish;

   // A new request may be taken in IDLE or in the DONE cycle, never while waiting.
   assign accept = mem_io.enable && (state_q != StWait);
   assign finish = (state_q == StWait) && (cnt_q == 4'd1);

   // Address bits above the word index do not select storage.
   if (DEPTH_LOG2 < 15) begin : g_unused_addr
      logic unused_addr_hi;
      assign unused_addr_hi = ^mem_io.addr[15:DEPTH_LOG2+1];
   end

   // Next-state, capture and completion logic.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      idx_d      = idx_q;
      wr_d       = wr_q;
      addr0_d    = addr0_q;
      wdata_d    = wdata_q;
      dout_d     = dout_q;
      misalign_d = 1'b0;
      unique case (state_q)
         StIdle, StDone: begin
            if (accept) begin
               state_d = StWait;
               cnt_d   = CntLoad;
               idx_d   = mem_io.addr[DEPTH_LOG2:1];
               wr_d    = mem_io.wr;
               addr0_d = mem_io.addr[0];
               wdata_d = mem_io.data_in;
            end else begin
               state_d = StIdle;
            end
         end
         StWait: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               state_d    = StDone;
               misalign_d = addr0_q;
               if (!wr_q) begin
                  dout_d = mem[idx_q];
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Control and output registers; reset aborts any request in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         cnt_q      <= 4'd0;
         idx_q      <= '0;
         wr_q       <= 1'b0;
         addr0_q    <= 1'b0;
         wdata_q    <= 16'h0000;
         dout_q     <= 16'h0000;
         misalign_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         wr_q       <= wr_d;
         addr0_q    <= addr0_d;
         wdata_q    <= wdata_d;
         dout_q     <= dout_d;
         misalign_q <= misalign_d;
      end
   end

   // Word array, written on the edge entering DONE; contents survive reset.
   always_ff @(posedge clk) begin
      if (finish && wr_q) begin
         mem[idx_q] <= wdata_q;
      end
   end

   assign mem_io.busy       = (state_q == StWait);
   assign mem_io.data_valid = (state_q == StDone);
   assign mem_io.misalign   = misalign_q;
   assign mem_io.data_out   = dout_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: driver pushes expected completions, monitor
// checks every cycle. A second LATENCY=2 instance checks back-to-back throughput.
module tb_dmem_responder;

   localparam int unsigned Lat = 4;
   localparam int unsigned D   = 8;

   typedef struct {
      bit          is_load;
      logic [15:0] data;
      bit          mis;
      int          acc;
      int          due;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   dmem_responder_if bus ();
   dmem_responder_if bus2 ();

   dmem_responder #(.LATENCY(Lat), .DEPTH_LOG2(D)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .mem_io (bus)
   );

   dmem_responder #(.LATENCY(2), .DEPTH_LOG2(D)) dut2 (
      .clk    (clk),
      .rst_n  (rst_n),
      .mem_io (bus2)
   );

   exp_t        q[$];
   int          cyc = 0;
   int          n_chk = 0;
   int          n_err = 0;
   bit          in_reset = 1'b1;
   logic [15:0] ref_mem [1 << D];
   logic [15:0] exp_dout = 16'h0000;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: one step per falling edge, compares the DUT against the queue.
   task automatic mon_step();
      exp_t e;
      bit   busy_exp;
      while (q.size() > 0 && q[0].due < cyc) begin
         chk("missing_valid", 32'd0, 32'd1);
         void'(q.pop_front());
      end
      busy_exp = 1'b0;
      foreach (q[i]) if (q[i].acc <= cyc && cyc < q[i].due) busy_exp = 1'b1;
      if (q.size() > 0 && q[0].due == cyc) begin
         e = q.pop_front();
         chk("valid", bus.data_valid, 1);
         chk("misalign", bus.misalign, e.mis);
         if (e.is_load) exp_dout = e.data;
      end else begin
         chk("valid", bus.data_valid, 0);
         chk("misalign_idle", bus.misalign, 0);
      end
      chk("busy", bus.busy, busy_exp);
      chk("data_out", bus.data_out, exp_dout);
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (!in_reset) mon_step();
      end
   end

   // Present a request from a falling edge, hold it until the DUT can take it.
   task automatic req(input bit w, input logic [15:0] a, input logic [15:0] d);
      int          n;
      logic [D-1:0] ix;
      exp_t        e;
      n = 0;
      @(negedge clk);
      bus.enable  = 1'b1;
      bus.wr      = w;
      bus.addr    = a;
      bus.data_in = d;
      while (bus.busy === 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) begin
         chk("accept_timeout", 32'd1, 32'd0);
         return;
      end
      ix        = a[D:1];
      e.is_load = !w;
      e.mis     = a[0];
      e.acc     = cyc + 1;
      e.due     = cyc + Lat;
      e.data    = w ? d : ref_mem[ix];
      if (w) ref_mem[ix] = d;
      q.push_back(e);
      @(posedge clk);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         bus.enable = 1'b0;
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (q.size() > 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (q.size() > 0) begin
         chk("drain_timeout", q.size(), 0);
         q.delete();
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_busy"}, bus.busy, 0);
      chk({tag, "_valid"}, bus.data_valid, 0);
      chk({tag, "_mis"}, bus.misalign, 0);
      chk({tag, "_dout"}, bus.data_out, 0);
   endtask

   initial begin
      logic [15:0] old;
      bus.enable  = 1'b0;
      bus.wr      = 1'b0;
      bus.addr    = 16'h0000;
      bus.data_in = 16'h0000;
      bus2.enable  = 1'b0;
      bus2.wr      = 1'b0;
      bus2.addr    = 16'h0000;
      bus2.data_in = 16'h0000;
      #1;
      chk_zero("reset");

      // Release just after a rising edge so the next edge is the first one out of reset.
      @(posedge clk);
      #2;
      rst_n    = 1'b1;
      in_reset = 1'b0;

      // Fill every word, with junk in the ignored upper address bits.
      for (int i = 0; i < (1 << D); i++) begin
         logic [15:0] a;
         a = 16'($urandom);
         a[D:0] = {i[D-1:0], 1'b0};
         req(1'b1, a, 16'($urandom));
      end
      idle(1);
      drain();

      req(1'b1, 16'h0010, 16'hBEEF);
      idle(5);
      req(1'b0, 16'h0010, 16'h0000);
      idle(6);

      // Load held while the store is busy, taken in the DONE cycle.
      req(1'b1, 16'h0020, 16'h1234);
      req(1'b0, 16'h0020, 16'h0000);
      idle(6);

      req(1'b1, 16'h0030, 16'hA5A5);
      req(1'b0, 16'h0031, 16'h0000);
      idle(6);

      req(1'b1, 16'h0050, 16'h0001);
      req(1'b0, 16'h0050, 16'h0000);
      req(1'b1, 16'h0060, 16'h7777);
      idle(6);
      drain();

      // Reset in the second busy cycle of a store aborts it.
      old = ref_mem[8'h20];
      req(1'b1, 16'h0040, 16'hFFFF);
      @(negedge clk);
      bus.enable = 1'b0;
      @(negedge clk);
      #2;
      rst_n    = 1'b0;
      in_reset = 1'b1;
      #1;
      chk_zero("abort");
      q.delete();
      ref_mem[8'h20] = old;
      exp_dout = 16'h0000;
      @(posedge clk);
      #2;
      rst_n    = 1'b1;
      in_reset = 1'b0;
      req(1'b0, 16'h0040, 16'h0000);
      idle(6);
      drain();

      repeat (300) begin
         req(1'($urandom), 16'($urandom), 16'($urandom));
         if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 5));
      end
      idle(1);
      drain();

      // LATENCY=2: request held on every edge gives alternating busy / valid cycles.
      @(negedge clk);
      bus2.enable  = 1'b1;
      bus2.wr      = 1'b1;
      bus2.addr    = 16'h0002;
      bus2.data_in = 16'h2000;
      for (int i = 1; i <= 22; i++) begin
         @(negedge clk);
         chk("l2_busy", bus2.busy, 32'(i % 2));
         chk("l2_valid", bus2.data_valid, 32'((i % 2) == 0));
         chk("l2_dout", bus2.data_out, (i == 22) ? 32'h2012 : 32'h0);
         bus2.data_in = 16'(16'h2000 + i);
         if (i == 20) bus2.wr = 1'b0;
         if (i == 22) bus2.enable = 1'b0;
      end
      @(negedge clk);
      chk("l2_end_valid", bus2.data_valid, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
